uc_compara_tiros_e_asteroides: RTL and testbench
================================================

UC_COMPARA_TIROS_E_ASTEROIDES -- requirements
Module: uc_compara_tiros_e_asteroides

Interface
REQ-001 Parameter N_TIROS, default 8, number of shot slots (power of two).
REQ-002 Parameter N_ASTEROIDES, default 16, number of asteroid slots (power of two).
REQ-003 clock  in  1  single system clock; all state changes on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 iniciar  in  1  start request; sampled only in ESPERA.
REQ-006 tiro_valido  in  1  loaded bit of shot at endereco_tiro; valid one cycle after the address changes.
REQ-007 asteroide_valido  in  1  loaded and not destroyed, for the asteroid at endereco_asteroide; same one-cycle timing.
REQ-008 posicao_tiro_igual_asteroide  in  1  comparator result for the current shot/asteroid pair.
REQ-009 endereco_tiro  out  log2(N_TIROS)  shot memory address = internal shot counter.
REQ-010 endereco_asteroide  out  log2(N_ASTEROIDES)  asteroid memory address = internal asteroid counter.
REQ-011 enable_mem_tiro, enable_mem_asteroide  out  1 each  write strobes for the shot and asteroid memories.
REQ-012 new_loaded_tiro  out  1  write data for shot loaded bit; 0 in DESTROI, else 1.
REQ-013 new_destruido_asteroide  out  1  write data for asteroid destroyed bit; 1 in DESTROI, else 0.
REQ-014 pontua  out  1  one-cycle score-increment pulse per destroyed asteroid.
REQ-015 ocupado  out  1  high in every state except INICIO and ESPERA.
REQ-016 fim_compara_tiros_e_asteroides  out  1  one-cycle done pulse.
REQ-017 db_estado  out  5  encoded current state, for debugging.

Function
REQ-018 The block SHALL be a Moore FSM; all outputs SHALL decode from the state register and counters only.
REQ-019 State encoding: INICIO=0, ESPERA=1, CARREGA_TIRO=2, VERIFICA_TIRO=3, CARREGA_ASTEROIDE=4, COMPARA=5, DESTROI=6, PROXIMO_ASTEROIDE=7, PROXIMO_TIRO=8, FIM=9, ERRO=F.
REQ-020 Transitions:
  - INICIO->ESPERA.
  - ESPERA->CARREGA_TIRO if iniciar, else stay in ESPERA; both counters are cleared on entry to CARREGA_TIRO from ESPERA.
  - CARREGA_TIRO->VERIFICA_TIRO.
  - VERIFICA_TIRO->CARREGA_ASTEROIDE if tiro_valido, else ->PROXIMO_TIRO.
  - CARREGA_ASTEROIDE->COMPARA.
  - COMPARA->DESTROI if asteroide_valido AND posicao_tiro_igual_asteroide, else ->PROXIMO_ASTEROIDE.
  - DESTROI->PROXIMO_TIRO; the shot is consumed and its remaining asteroids are skipped.
  - PROXIMO_ASTEROIDE->PROXIMO_TIRO if the asteroid counter is at its last value, else increment the asteroid counter and ->CARREGA_ASTEROIDE.
  - PROXIMO_TIRO->FIM if the shot counter is at its last value, else increment the shot counter, clear the asteroid counter and ->CARREGA_TIRO.
  - FIM->ESPERA.
  - Unused encodings ->INICIO.
REQ-021 DESTROI SHALL assert enable_mem_tiro, enable_mem_asteroide and pontua for exactly one cycle at the current addresses.
REQ-022 iniciar outside ESPERA SHALL be ignored and SHALL NOT be queued.
REQ-023 Counters SHALL NOT wrap during a pass; wrap occurs only through the explicit clear.
REQ-024 An invalid shot SHALL cost 3 cycles.
REQ-025 A valid shot with no hit SHALL cost 2+3*N_ASTEROIDES+1 cycles.

Reset
REQ-026 When reset is low: state=INICIO, both counters=0, all strobes and pulses=0, ocupado=0, db_estado=0, new_loaded_tiro=1, new_destruido_asteroide=0.
REQ-027 Reset asserted mid-pass SHALL abort immediately; no write strobe SHALL be emitted and no fim pulse SHALL follow.

Structure
REQ-028 State encodings, N_TIROS and N_ASTEROIDES defaults SHALL live in the shared game constants package.
REQ-029 One sub-module SHALL be used: contador_m (modulo counter with clear, enable and rco), instantiated once for shots and once for asteroids.

Verification
REQ-030 All shots invalid, iniciar pulse: fim rises 25 cycles after the sampling edge; no write strobes; pontua never asserted.
REQ-031 Only shot 0 valid, asteroid 5 valid and matching: exactly one DESTROI with endereco_tiro=0 and endereco_asteroide=5; pontua=1 for one cycle; asteroids 6..15 are not visited for shot 0.
REQ-032 Only shot 7 valid, matching asteroid 15 (last slot): DESTROI at addresses 7/15, then FIM on the next-but-one cycle.
REQ-033 Match asserted but asteroide_valido=0: no DESTROI; the pass continues to asteroid+1.
REQ-034 iniciar held high throughout: exactly one pass, then ESPERA for one cycle, then a new pass starts.
REQ-035 Reset driven low during COMPARA: state, db_estado and both counters read 0 at once; no strobes are emitted after reset is released.

Source files
------------

// File: rtl/uc_compara_tiros_e_asteroides_pkg.sv
// Shared game constants: slot counts, state encoding and the Moore output decode.
// Pure declarations, no latency or flow control of its own.
package uc_compara_tiros_e_asteroides_pkg;

    localparam int N_TIROS_DEF      = 8;
    localparam int N_ASTEROIDES_DEF = 16;

    typedef enum logic [3:0] {
        INICIO            = 4'h0,
        ESPERA            = 4'h1,
        CARREGA_TIRO      = 4'h2,
        VERIFICA_TIRO     = 4'h3,
        CARREGA_ASTEROIDE = 4'h4,
        COMPARA           = 4'h5,
        DESTROI           = 4'h6,
        PROXIMO_ASTEROIDE = 4'h7,
        PROXIMO_TIRO      = 4'h8,
        FIM               = 4'h9,
        ERRO              = 4'hF
    } estado_t;

    typedef struct packed {
        logic enable_mem_tiro;
        logic enable_mem_asteroide;
        logic new_loaded_tiro;
        logic new_destruido_asteroide;
        logic pontua;
        logic ocupado;
        logic fim;
    } saidas_t;

    function automatic saidas_t decodifica(estado_t e);
        saidas_t s;
        s.enable_mem_tiro         = (e == DESTROI);
        s.enable_mem_asteroide    = (e == DESTROI);
        s.new_loaded_tiro         = (e != DESTROI);
        s.new_destruido_asteroide = (e == DESTROI);
        s.pontua                  = (e == DESTROI);
        s.ocupado                 = (e != INICIO) && (e != ESPERA);
        s.fim                     = (e == FIM);
        return s;
    endfunction

endpackage

// File: rtl/uc_compara_tiros_e_asteroides_contador_m.sv
// Modulo-M counter with synchronous clear (priority over enable) and terminal-count rco.
// Count updates one cycle after enable; no backpressure.
module contador_m #(
    parameter int M = 16,
    parameter int W = $clog2(M)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         enable,
    output logic [W-1:0] q,
    output logic         rco
);

    assign rco = (q == W'(M - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (enable) begin
            q <= rco ? '0 : q + 1'b1;
        end
    end

endmodule

// File: rtl/uc_compara_tiros_e_asteroides.sv
// Control unit sweeping every shot against every asteroid, flagging hits for write-back.
// Moore outputs valid one cycle after each transition; iniciar is only honoured in ESPERA.
module uc_compara_tiros_e_asteroides
    import uc_compara_tiros_e_asteroides_pkg::*;
#(
    parameter int N_TIROS      = N_TIROS_DEF,
    parameter int N_ASTEROIDES = N_ASTEROIDES_DEF
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            iniciar,
    input  logic                            tiro_valido,
    input  logic                            asteroide_valido,
    input  logic                            posicao_tiro_igual_asteroide,
    output logic [$clog2(N_TIROS)-1:0]      endereco_tiro,
    output logic [$clog2(N_ASTEROIDES)-1:0] endereco_asteroide,
    output logic                            enable_mem_tiro,
    output logic                            enable_mem_asteroide,
    output logic                            new_loaded_tiro,
    output logic                            new_destruido_asteroide,
    output logic                            pontua,
    output logic                            ocupado,
    output logic                            fim_compara_tiros_e_asteroides,
    output logic [4:0]                      db_estado
);

    estado_t estado;
    estado_t proximo;
    saidas_t saidas;
    logic    rco_tiro;
    logic    rco_asteroide;
    logic    partida;
    logic    en_tiro;
    logic    en_asteroide;

    // Counters never advance past their last slot; they only return to zero via clear.
    assign partida      = (estado == ESPERA) && iniciar;
    assign en_tiro      = (estado == PROXIMO_TIRO) && !rco_tiro;
    assign en_asteroide = (estado == PROXIMO_ASTEROIDE) && !rco_asteroide;

    contador_m #(.M(N_TIROS)) u_cont_tiro (
        .clock  (clock),
        .reset  (reset),
        .clear  (partida),
        .enable (en_tiro),
        .q      (endereco_tiro),
        .rco    (rco_tiro)
    );

    contador_m #(.M(N_ASTEROIDES)) u_cont_asteroide (
        .clock  (clock),
        .reset  (reset),
        .clear  (partida || en_tiro),
        .enable (en_asteroide),
        .q      (endereco_asteroide),
        .rco    (rco_asteroide)
    );

    always_comb begin
        proximo = INICIO;
        case (estado)
            INICIO:            proximo = ESPERA;
            ESPERA:            proximo = iniciar ? CARREGA_TIRO : ESPERA;
            CARREGA_TIRO:      proximo = VERIFICA_TIRO;
            VERIFICA_TIRO:     proximo = tiro_valido ? CARREGA_ASTEROIDE : PROXIMO_TIRO;
            CARREGA_ASTEROIDE: proximo = COMPARA;
            COMPARA:           proximo = (asteroide_valido && posicao_tiro_igual_asteroide)
                                         ? DESTROI : PROXIMO_ASTEROIDE;
            DESTROI:           proximo = PROXIMO_TIRO;
            PROXIMO_ASTEROIDE: proximo = rco_asteroide ? PROXIMO_TIRO : CARREGA_ASTEROIDE;
            PROXIMO_TIRO:      proximo = rco_tiro ? FIM : CARREGA_TIRO;
            FIM:               proximo = ESPERA;
            default:           proximo = INICIO;
        endcase
    end

    // Outputs are registered from the decode of the next state, so they always match estado.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado <= INICIO;
            saidas <= decodifica(INICIO);
        end else begin
            estado <= proximo;
            saidas <= decodifica(proximo);
        end
    end

    assign enable_mem_tiro                = saidas.enable_mem_tiro;
    assign enable_mem_asteroide           = saidas.enable_mem_asteroide;
    assign new_loaded_tiro                = saidas.new_loaded_tiro;
    assign new_destruido_asteroide        = saidas.new_destruido_asteroide;
    assign pontua                         = saidas.pontua;
    assign ocupado                        = saidas.ocupado;
    assign fim_compara_tiros_e_asteroides = saidas.fim;
    assign db_estado                      = {1'b0, estado};

endmodule

// File: tb/tb_uc_compara_tiros_e_asteroides.sv
// Directed bench for the shot/asteroid comparison control unit with behavioural slot memories.
module tb_uc_compara_tiros_e_asteroides;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       iniciar = 1'b0;
    logic       tiro_valido;
    logic       asteroide_valido;
    logic       posicao_tiro_igual_asteroide;
    logic [2:0] endereco_tiro;
    logic [3:0] endereco_asteroide;
    logic       enable_mem_tiro;
    logic       enable_mem_asteroide;
    logic       new_loaded_tiro;
    logic       new_destruido_asteroide;
    logic       pontua;
    logic       ocupado;
    logic       fim_compara_tiros_e_asteroides;
    logic [4:0] db_estado;

    logic [7:0]  mem_tiro;
    logic [15:0] mem_ast;
    logic        match_en;
    logic [2:0]  match_t;
    logic [3:0]  match_a;

    int checks = 0;
    int failures = 0;

    int n_wr_t = 0, n_wr_a = 0, n_pont = 0, n_fim = 0, n_cmp = 0, cyc_now = 0;
    int pont_cyc = 0;
    logic [2:0] pont_t = '0;
    logic [3:0] pont_a = '0;
    logic       pont_nl = 1'b1, pont_nd = 1'b0;

    int t0;
    int b_wr_t, b_wr_a, b_pont, b_fim, b_cmp;

    always #5 clock = ~clock;

    assign tiro_valido      = mem_tiro[endereco_tiro];
    assign asteroide_valido = mem_ast[endereco_asteroide];
    assign posicao_tiro_igual_asteroide = match_en && (endereco_tiro == match_t)
                                          && (endereco_asteroide == match_a);

    uc_compara_tiros_e_asteroides dut (
        .clock                          (clock),
        .reset                          (reset),
        .iniciar                        (iniciar),
        .tiro_valido                    (tiro_valido),
        .asteroide_valido               (asteroide_valido),
        .posicao_tiro_igual_asteroide   (posicao_tiro_igual_asteroide),
        .endereco_tiro                  (endereco_tiro),
        .endereco_asteroide             (endereco_asteroide),
        .enable_mem_tiro                (enable_mem_tiro),
        .enable_mem_asteroide           (enable_mem_asteroide),
        .new_loaded_tiro                (new_loaded_tiro),
        .new_destruido_asteroide        (new_destruido_asteroide),
        .pontua                         (pontua),
        .ocupado                        (ocupado),
        .fim_compara_tiros_e_asteroides (fim_compara_tiros_e_asteroides),
        .db_estado                      (db_estado)
    );

    always @(negedge clock) begin
        cyc_now++;
        if (enable_mem_tiro) n_wr_t++;
        if (enable_mem_asteroide) n_wr_a++;
        if (fim_compara_tiros_e_asteroides) n_fim++;
        if (db_estado == 5'd5) n_cmp++;
        if (pontua) begin
            n_pont++;
            pont_cyc = cyc_now;
            pont_t   = endereco_tiro;
            pont_a   = endereco_asteroide;
            pont_nl  = new_loaded_tiro;
            pont_nd  = new_destruido_asteroide;
        end
    end

    task automatic snapshot();
        b_wr_t = n_wr_t; b_wr_a = n_wr_a; b_pont = n_pont; b_fim = n_fim; b_cmp = n_cmp;
    endtask

    // Cycle 1 is the cycle right after the edge that samples iniciar.
    task automatic start_pass();
        @(negedge clock);
        iniciar = 1'b1;
        @(posedge clock);
        t0 = cyc_now;
        snapshot();
        #1 iniciar = 1'b0;
    endtask

    task automatic wait_fim(input int budget, output int c);
        c = 0;
        forever begin
            @(negedge clock);
            c++;
            if (fim_compara_tiros_e_asteroides === 1'b1) break;
            if (c >= budget) begin
                c = -1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        mem_tiro = '0; mem_ast = '0; match_en = 1'b0; match_t = '0; match_a = '0;
        #2 reset = 1'b0;
        #1;
        checks++;
        if (db_estado !== 5'd0 || endereco_tiro !== 3'd0 || endereco_asteroide !== 4'd0) begin
            failures++;
            $display("FAIL reset_state: db_estado=%0d tiro=%0d ast=%0d, required 0/0/0",
                     db_estado, endereco_tiro, endereco_asteroide);
        end
        checks++;
        if ({enable_mem_tiro, enable_mem_asteroide, pontua, ocupado,
             fim_compara_tiros_e_asteroides, new_loaded_tiro, new_destruido_asteroide} !== 7'b0000010) begin
            failures++;
            $display("FAIL reset_outputs: got %b, required 0000010",
                     {enable_mem_tiro, enable_mem_asteroide, pontua, ocupado,
                      fim_compara_tiros_e_asteroides, new_loaded_tiro, new_destruido_asteroide});
        end
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        checks++;
        if (db_estado !== 5'd1 || ocupado !== 1'b0) begin
            failures++;
            $display("FAIL reset_to_espera: db_estado=%0d ocupado=%b, required 1/0", db_estado, ocupado);
        end
    endtask

    task automatic test_all_invalid();
        int c;
        mem_tiro = '0; mem_ast = '1; match_en = 1'b0;
        start_pass();
        wait_fim(100, c);
        @(negedge clock); #1;
        checks++;
        if (c !== 25) begin
            failures++;
            $display("FAIL invalid_fim_cycle: got %0d, required 25", c);
        end
        checks++;
        if (n_wr_t - b_wr_t !== 0 || n_wr_a - b_wr_a !== 0 || n_pont - b_pont !== 0) begin
            failures++;
            $display("FAIL invalid_no_writes: wr_t=%0d wr_a=%0d pontua=%0d, required 0/0/0",
                     n_wr_t - b_wr_t, n_wr_a - b_wr_a, n_pont - b_pont);
        end
        checks++;
        if (n_fim - b_fim !== 1 || n_cmp - b_cmp !== 0) begin
            failures++;
            $display("FAIL invalid_counts: fim=%0d compara=%0d, required 1/0", n_fim - b_fim, n_cmp - b_cmp);
        end
    endtask

    task automatic test_hit_shot0();
        int c;
        mem_tiro = 8'h01; mem_ast = 16'h0020; match_en = 1'b1; match_t = 3'd0; match_a = 4'd5;
        start_pass();
        wait_fim(100, c);
        @(negedge clock); #1;
        checks++;
        if (c !== 43) begin
            failures++;
            $display("FAIL hit0_fim_cycle: got %0d, required 43", c);
        end
        checks++;
        if (n_pont - b_pont !== 1 || n_wr_t - b_wr_t !== 1 || n_wr_a - b_wr_a !== 1) begin
            failures++;
            $display("FAIL hit0_strobes: pontua=%0d wr_t=%0d wr_a=%0d, required 1/1/1",
                     n_pont - b_pont, n_wr_t - b_wr_t, n_wr_a - b_wr_a);
        end
        checks++;
        if (pont_t !== 3'd0 || pont_a !== 4'd5 || pont_nl !== 1'b0 || pont_nd !== 1'b1) begin
            failures++;
            $display("FAIL hit0_addr_data: tiro=%0d ast=%0d loaded=%b destruido=%b, required 0/5/0/1",
                     pont_t, pont_a, pont_nl, pont_nd);
        end
        checks++;
        if (n_cmp - b_cmp !== 6) begin
            failures++;
            $display("FAIL hit0_visits: compara=%0d, required 6", n_cmp - b_cmp);
        end
    endtask

    task automatic test_hit_last_slot();
        int c;
        mem_tiro = 8'h80; mem_ast = 16'h8000; match_en = 1'b1; match_t = 3'd7; match_a = 4'd15;
        start_pass();
        wait_fim(100, c);
        @(negedge clock); #1;
        checks++;
        if (c !== 73 || pont_cyc - t0 !== 71) begin
            failures++;
            $display("FAIL last_timing: fim=%0d destroi=%0d, required 73/71", c, pont_cyc - t0);
        end
        checks++;
        if (pont_t !== 3'd7 || pont_a !== 4'd15 || n_pont - b_pont !== 1) begin
            failures++;
            $display("FAIL last_addr: tiro=%0d ast=%0d pontua=%0d, required 7/15/1",
                     pont_t, pont_a, n_pont - b_pont);
        end
        checks++;
        if (n_cmp - b_cmp !== 16) begin
            failures++;
            $display("FAIL last_visits: compara=%0d, required 16", n_cmp - b_cmp);
        end
    endtask

    task automatic test_match_invalid_ast();
        int c;
        mem_tiro = 8'h01; mem_ast = '0; match_en = 1'b1; match_t = 3'd0; match_a = 4'd3;
        start_pass();
        wait_fim(100, c);
        @(negedge clock); #1;
        checks++;
        if (c !== 73) begin
            failures++;
            $display("FAIL nohit_fim_cycle: got %0d, required 73", c);
        end
        checks++;
        if (n_pont - b_pont !== 0 || n_wr_t - b_wr_t !== 0 || n_cmp - b_cmp !== 16) begin
            failures++;
            $display("FAIL nohit_counts: pontua=%0d wr_t=%0d compara=%0d, required 0/0/16",
                     n_pont - b_pont, n_wr_t - b_wr_t, n_cmp - b_cmp);
        end
    endtask

    task automatic test_ignore_busy_start();
        int c;
        mem_tiro = '0; match_en = 1'b0;
        start_pass();
        repeat (5) @(negedge clock);
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
        wait_fim(100, c);
        checks++;
        if (c !== 19) begin
            failures++;
            $display("FAIL ignore_fim_cycle: got %0d, required 19", c);
        end
        repeat (2) @(negedge clock);
        checks++;
        if (db_estado !== 5'd1) begin
            failures++;
            $display("FAIL ignore_not_queued: db_estado=%0d, required 1", db_estado);
        end
    endtask

    task automatic test_back_to_back();
        int c;
        mem_tiro = '0; match_en = 1'b0;
        @(negedge clock);
        iniciar = 1'b1;
        @(posedge clock);
        wait_fim(100, c);
        checks++;
        if (c !== 25) begin
            failures++;
            $display("FAIL b2b_first_fim: got %0d, required 25", c);
        end
        @(negedge clock);
        checks++;
        if (db_estado !== 5'd1) begin
            failures++;
            $display("FAIL b2b_espera: db_estado=%0d, required 1", db_estado);
        end
        @(negedge clock);
        checks++;
        if (db_estado !== 5'd2 || ocupado !== 1'b1) begin
            failures++;
            $display("FAIL b2b_restart: db_estado=%0d ocupado=%b, required 2/1", db_estado, ocupado);
        end
        iniciar = 1'b0;
        wait_fim(100, c);
        checks++;
        if (c !== 24) begin
            failures++;
            $display("FAIL b2b_second_fim: got %0d, required 24", c);
        end
        repeat (2) @(negedge clock);
    endtask

    task automatic test_reset_mid_pass();
        int c;
        mem_tiro = 8'h01; mem_ast = 16'h0020; match_en = 1'b1; match_t = 3'd0; match_a = 4'd5;
        start_pass();
        c = 0;
        while (!(db_estado == 5'd5 && endereco_asteroide == 4'd2) && c < 100) begin
            @(negedge clock);
            c++;
        end
        checks++;
        if (c >= 100) begin
            failures++;
            $display("FAIL midreset_reach_compara: db_estado=%0d ast=%0d, required 5/2", db_estado, endereco_asteroide);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (db_estado !== 5'd0 || endereco_tiro !== 3'd0 || endereco_asteroide !== 4'd0 || ocupado !== 1'b0) begin
            failures++;
            $display("FAIL midreset_abort: db_estado=%0d tiro=%0d ast=%0d ocupado=%b, required 0/0/0/0",
                     db_estado, endereco_tiro, endereco_asteroide, ocupado);
        end
        @(negedge clock);
        reset = 1'b1;
        repeat (80) @(negedge clock);
        #1;
        checks++;
        if (n_wr_t - b_wr_t !== 0 || n_wr_a - b_wr_a !== 0 || n_pont - b_pont !== 0 || n_fim - b_fim !== 0) begin
            failures++;
            $display("FAIL midreset_quiet: wr_t=%0d wr_a=%0d pontua=%0d fim=%0d, required 0/0/0/0",
                     n_wr_t - b_wr_t, n_wr_a - b_wr_a, n_pont - b_pont, n_fim - b_fim);
        end
        checks++;
        if (db_estado !== 5'd1) begin
            failures++;
            $display("FAIL midreset_idle: db_estado=%0d, required 1", db_estado);
        end
    endtask

    initial begin
        test_reset();
        test_all_invalid();
        test_hit_shot0();
        test_hit_last_slot();
        test_match_invalid_ast();
        test_ignore_busy_start();
        test_back_to_back();
        test_reset_mid_pass();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
